// File: rtl/operand_forward_buffer.sv
// Operand forwarding buffer: in-order FIFO of issued instructions whose
// source operands are completed from the common data bus while they wait.
module operand_forward_buffer #(
   parameter int XLEN          = 32,
   parameter int TAG_WIDTH     = 6,
   parameter int SRC_COUNT     = 2,
   parameter int CDB_COUNT     = 2,
   parameter int DEPTH         = 4,
   parameter int PAYLOAD_W     = 96,
   parameter int WAIT_OPERANDS = 0
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [SRC_COUNT*TAG_WIDTH-1:0] in_tag,
   input  logic [SRC_COUNT*XLEN-1:0]      in_rf_data,
   input  logic [SRC_COUNT-1:0]           in_rf_valid,
   input  logic [PAYLOAD_W-1:0]           in_payload,
   input  logic [CDB_COUNT-1:0]           cdb_valid,
   input  logic [CDB_COUNT*TAG_WIDTH-1:0] cdb_tag,
   input  logic [CDB_COUNT*XLEN-1:0]      cdb_data,
   input  logic                           flush,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [PAYLOAD_W-1:0]           out_payload,
   output logic [SRC_COUNT*XLEN-1:0]      out_data,
   output logic [SRC_COUNT-1:0]           out_op_valid,
   output logic [$clog2(DEPTH):0]         count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef logic [CDB_COUNT-1:0][TAG_WIDTH-1:0] cdb_tag_t;
   typedef logic [CDB_COUNT-1:0][XLEN-1:0]      cdb_data_t;

   // per-lane views of the flat buses
   logic [SRC_COUNT-1:0][TAG_WIDTH-1:0] in_tag_a;
   logic [SRC_COUNT-1:0][XLEN-1:0]      in_rf_a;
   cdb_tag_t                            cdb_tag_a;
   cdb_data_t                           cdb_data_a;

   assign in_tag_a   = in_tag;
   assign in_rf_a    = in_rf_data;
   assign cdb_tag_a  = cdb_tag;
   assign cdb_data_a = cdb_data;

   // entry storage
   logic [SRC_COUNT-1:0][TAG_WIDTH-1:0] tag_q  [DEPTH];
   logic [SRC_COUNT-1:0][TAG_WIDTH-1:0] tag_d  [DEPTH];
   logic [SRC_COUNT-1:0][XLEN-1:0]      data_q [DEPTH];
   logic [SRC_COUNT-1:0][XLEN-1:0]      data_d [DEPTH];
   logic [SRC_COUNT-1:0]                vld_q  [DEPTH];
   logic [SRC_COUNT-1:0]                vld_d  [DEPTH];
   logic [PAYLOAD_W-1:0]                pay_q  [DEPTH];
   logic [PAYLOAD_W-1:0]                pay_d  [DEPTH];

   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic enq, deq;
   logic [SRC_COUNT-1:0][XLEN-1:0] head_data;

   // Bus lookup: {hit, data}. Scanned high to low so the lowest channel wins;
   // tag 0 means "no producer" and never matches.
   function automatic logic [XLEN:0] cdb_lookup(input logic [TAG_WIDTH-1:0] t,
                                                 input logic [CDB_COUNT-1:0] v,
                                                 input cdb_tag_t ct,
                                                 input cdb_data_t cd);
      logic [XLEN:0] r;
      r = '0;
      for (int c = CDB_COUNT - 1; c >= 0; c--)
         if (v[c] && ct[c] == t && t != '0) r = {1'b1, cd[c]};
      return r;
   endfunction

   // Handshakes; reset_n gates in_ready so nothing is accepted while in reset.
   assign in_ready = reset_n && (cnt_q < CNT_W'(DEPTH)) && !flush;
   assign enq      = in_valid && in_ready;
   assign deq      = out_valid && out_ready;
   assign count    = cnt_q;

   // Head presentation with same-cycle bus bypass for still-pending operands.
   always_comb begin
      logic [XLEN:0] m;
      m            = '0;
      head_data    = data_q[rd_q];
      out_op_valid = vld_q[rd_q];
      for (int s = 0; s < SRC_COUNT; s++) begin
         m = cdb_lookup(tag_q[rd_q][s], cdb_valid, cdb_tag_a, cdb_data_a);
         if (!vld_q[rd_q][s] && m[XLEN]) begin
            out_op_valid[s] = 1'b1;
            head_data[s]    = m[XLEN-1:0];
         end
      end
      out_data    = head_data;
      out_payload = pay_q[rd_q];
      out_valid   = (cnt_q != '0) && ((WAIT_OPERANDS == 0) || (&out_op_valid));
   end

   // Next state: snoop pending operands, then apply flush or enqueue/dequeue.
   always_comb begin
      logic [XLEN:0] m;
      m      = '0;
      tag_d  = tag_q;
      data_d = data_q;
      vld_d  = vld_q;
      pay_d  = pay_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      cnt_d  = cnt_q;
      // stored operands that are already valid are never overwritten
      for (int e = 0; e < DEPTH; e++)
         for (int s = 0; s < SRC_COUNT; s++) begin
            m = cdb_lookup(tag_q[e][s], cdb_valid, cdb_tag_a, cdb_data_a);
            if (!vld_q[e][s] && m[XLEN]) begin
               vld_d[e][s]  = 1'b1;
               data_d[e][s] = m[XLEN-1:0];
            end
         end
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (enq) begin
            tag_d[wr_q] = in_tag_a;
            pay_d[wr_q] = in_payload;
            // bus data is newer than the register file, so it wins on a hit
            for (int s = 0; s < SRC_COUNT; s++) begin
               m = cdb_lookup(in_tag_a[s], cdb_valid, cdb_tag_a, cdb_data_a);
               if (m[XLEN]) begin
                  data_d[wr_q][s] = m[XLEN-1:0];
                  vld_d[wr_q][s]  = 1'b1;
               end else begin
                  data_d[wr_q][s] = in_rf_a[s];
                  vld_d[wr_q][s]  = in_rf_valid[s];
               end
            end
            wr_d = wr_q + 1'b1;
         end
         if (deq) rd_d = rd_q + 1'b1;
         cnt_d = cnt_q + CNT_W'(enq) - CNT_W'(deq);
      end
   end

   // Control state and operand valid bits, cleared asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int e = 0; e < DEPTH; e++) vld_q[e] <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         vld_q <= vld_d;
      end
   end

   // Data-path storage needs no reset; validity is tracked by vld_q and count.
   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
      pay_q  <= pay_d;
   end

endmodule

// File: tb/tb_operand_forward_buffer.sv
// Directed bench for operand_forward_buffer: one instance per presentation
// mode on shared stimulus, with a queue of expected dequeued entries.
module tb_operand_forward_buffer;

   localparam int XL = 32;
   localparam int TW = 6;
   localparam int SC = 2;
   localparam int CC = 2;
   localparam int D  = 4;
   localparam int PW = 96;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              in_valid, flush, out_ready;
   logic [SC*TW-1:0]  in_tag;
   logic [SC*XL-1:0]  in_rf_data;
   logic [SC-1:0]     in_rf_valid;
   logic [PW-1:0]     in_payload;
   logic [CC-1:0]     cdb_valid;
   logic [CC*TW-1:0]  cdb_tag;
   logic [CC*XL-1:0]  cdb_data;

   logic              in_ready0, out_valid0, in_ready1, out_valid1;
   logic [PW-1:0]     out_payload0, out_payload1;
   logic [SC*XL-1:0]  out_data0, out_data1;
   logic [SC-1:0]     out_op_valid0, out_op_valid1;
   logic [2:0]        count0, count1;

   logic [PW+SC*XL-1:0] exp_q [$];
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   operand_forward_buffer #(.XLEN(XL), .TAG_WIDTH(TW), .SRC_COUNT(SC), .CDB_COUNT(CC),
      .DEPTH(D), .PAYLOAD_W(PW), .WAIT_OPERANDS(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
      .in_tag(in_tag), .in_rf_data(in_rf_data), .in_rf_valid(in_rf_valid),
      .in_payload(in_payload), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
      .cdb_data(cdb_data), .flush(flush), .out_valid(out_valid0), .out_ready(out_ready),
      .out_payload(out_payload0), .out_data(out_data0), .out_op_valid(out_op_valid0),
      .count(count0));

   operand_forward_buffer #(.XLEN(XL), .TAG_WIDTH(TW), .SRC_COUNT(SC), .CDB_COUNT(CC),
      .DEPTH(D), .PAYLOAD_W(PW), .WAIT_OPERANDS(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
      .in_tag(in_tag), .in_rf_data(in_rf_data), .in_rf_valid(in_rf_valid),
      .in_payload(in_payload), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
      .cdb_data(cdb_data), .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
      .out_payload(out_payload1), .out_data(out_data1), .out_op_valid(out_op_valid1),
      .count(count1));

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: at the falling edge score any dequeue of dut0, then step past the rising edge.
   task automatic cyc();
      logic [PW+SC*XL-1:0] e;
      @(negedge clk);
      if (out_valid0 && out_ready) begin
         if (exp_q.size() == 0) chk("deq_unexpected", 192'(out_payload0), 192'(0));
         else begin
            e = exp_q.pop_front();
            chk("deq_entry", 192'({out_payload0, out_data0}), 192'(e));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive_in(input logic [PW-1:0] pay, input logic [TW-1:0] t0, t1,
                           input logic [XL-1:0] d0, d1, input logic [1:0] rv);
      in_valid    = 1'b1;
      in_payload  = pay;
      in_tag      = {t1, t0};
      in_rf_data  = {d1, d0};
      in_rf_valid = rv;
   endtask

   task automatic set_cdb(input int ch, input logic v, input logic [TW-1:0] t, input logic [XL-1:0] d);
      cdb_valid[ch]          = v;
      cdb_tag[ch*TW +: TW]   = t;
      cdb_data[ch*XL +: XL]  = d;
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_tag = '0; in_rf_data = '0; in_rf_valid = '0; in_payload = '0;
      cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
      #12;
      chk("rst_count", 192'(count0), 192'(0));
      chk("rst_out_valid", 192'(out_valid0), 192'(0));
      chk("rst_in_ready", 192'(in_ready0), 192'(0));
      @(posedge clk); #1;
      reset_n = 1'b1; #1;
      chk("post_rst_in_ready", 192'(in_ready0), 192'(1));

      // same-cycle bus hit on channel 1 beats the register file at enqueue
      drive_in(96'hA1, 6'd5, 6'd0, 32'hDEAD, 32'h1234, 2'b10);
      set_cdb(0, 1'b1, 6'd9, 32'hBB);
      set_cdb(1, 1'b1, 6'd5, 32'hAA);
      cyc();
      in_valid = 1'b0; cdb_valid = '0;
      chk("enq_cdb_lane0", 192'(out_data0[XL-1:0]), 192'(32'hAA));
      chk("enq_cdb_opv", 192'(out_op_valid0), 192'(2'b11));
      chk("enq_latency_valid", 192'(out_valid0), 192'(1));
      chk("enq_count", 192'(count0), 192'(1));
      exp_q.push_back({96'hA1, 32'h1234, 32'hAA});
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      chk("deq_count", 192'(count0), 192'(0));

      // stored operand waits on tag 7; both channels carry it, channel 0 wins
      drive_in(96'hA2, 6'd7, 6'd0, 32'hDEAD, 32'h77, 2'b10);
      cyc();
      in_valid = 1'b0;
      chk("wait_opv", 192'(out_op_valid0), 192'(2'b10));
      set_cdb(0, 1'b1, 6'd7, 32'h11);
      set_cdb(1, 1'b1, 6'd7, 32'h22);
      #1;
      chk("bypass_opv", 192'(out_op_valid0), 192'(2'b11));
      chk("bypass_lane0", 192'(out_data0[XL-1:0]), 192'(32'h11));
      cyc();
      cdb_valid = '0;
      chk("snoop_lane0", 192'(out_data0[XL-1:0]), 192'(32'h11));
      chk("snoop_opv", 192'(out_op_valid0), 192'(2'b11));
      exp_q.push_back({96'hA2, 32'h77, 32'h11});
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;

      // tag 0 never matches; a valid operand is never overwritten
      drive_in(96'hA3, 6'd0, 6'd4, 32'h3, 32'h44, 2'b10);
      set_cdb(0, 1'b1, 6'd0, 32'h99);
      cyc();
      in_valid = 1'b0;
      chk("tag0_opv", 192'(out_op_valid0), 192'(2'b10));
      chk("tag0_lane0", 192'(out_data0[XL-1:0]), 192'(32'h3));
      set_cdb(1, 1'b1, 6'd4, 32'h55);
      #1;
      chk("tag0_bypass_opv", 192'(out_op_valid0), 192'(2'b10));
      chk("valid_kept_bypass", 192'(out_data0[2*XL-1:XL]), 192'(32'h44));
      cyc();
      cdb_valid = '0;
      chk("valid_kept_stored", 192'(out_data0[2*XL-1:XL]), 192'(32'h44));
      exp_q.push_back({96'hA3, 32'h44, 32'h3});
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;

      // fill to full; a full buffer refuses enqueue even while dequeuing
      for (int i = 0; i < 4; i++) begin
         drive_in(96'(32'hB0 + i), 6'd0, 6'd0, 32'h100 + i, 32'h200 + i, 2'b11);
         exp_q.push_back({96'(32'hB0 + i), 32'h200 + i, 32'h100 + i});
         cyc();
      end
      chk("full_in_ready", 192'(in_ready0), 192'(0));
      chk("full_count", 192'(count0), 192'(4));
      drive_in(96'hFF, 6'd0, 6'd0, 32'hF0, 32'hF1, 2'b11);
      out_ready = 1'b1;
      cyc();
      chk("full_no_enq_count", 192'(count0), 192'(3));
      drive_in(96'hB5, 6'd0, 6'd0, 32'h105, 32'h205, 2'b11);
      exp_q.push_back({96'hB5, 32'h205, 32'h105});
      cyc();
      chk("enq_deq_count", 192'(count0), 192'(3));
      in_valid = 1'b0; out_ready = 1'b0;

      // flush with a concurrent enqueue drops everything
      drive_in(96'hC0, 6'd0, 6'd0, 32'h1, 32'h2, 2'b11);
      flush = 1'b1;
      #1;
      chk("flush_out_valid_held", 192'(out_valid0), 192'(1));
      chk("flush_in_ready", 192'(in_ready0), 192'(0));
      cyc();
      in_valid = 1'b0; flush = 1'b0;
      exp_q.delete();
      chk("flush_count", 192'(count0), 192'(0));
      chk("flush_out_valid", 192'(out_valid0), 192'(0));
      chk("flush_count_w1", 192'(count1), 192'(0));

      // operand-wait mode: head appears in the cycle its last operand arrives
      drive_in(96'hD0, 6'd3, 6'd0, 32'hDEAD, 32'h66, 2'b10);
      cyc();
      in_valid = 1'b0;
      chk("w1_wait_out_valid", 192'(out_valid1), 192'(0));
      chk("w0_head_out_valid", 192'(out_valid0), 192'(1));
      set_cdb(0, 1'b1, 6'd3, 32'h5);
      out_ready = 1'b1;
      #1;
      chk("w1_bypass_out_valid", 192'(out_valid1), 192'(1));
      chk("w1_bypass_lane0", 192'(out_data1[XL-1:0]), 192'(32'h5));
      exp_q.push_back({96'hD0, 32'h66, 32'h5});
      cyc();
      cdb_valid = '0; out_ready = 1'b0;
      chk("w1_deq_count", 192'(count1), 192'(0));
      chk("w1_deq_out_valid", 192'(out_valid1), 192'(0));
      drive_in(96'hD1, 6'd0, 6'd0, 32'h7, 32'h8, 2'b11);
      cyc();
      in_valid = 1'b0;
      chk("w1_ready_latency", 192'(out_valid1), 192'(1));
      exp_q.push_back({96'hD1, 32'h8, 32'h7});
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;

      // asynchronous reset mid-stream, away from any clock edge
      for (int i = 0; i < 2; i++) begin
         drive_in(96'(32'hE0 + i), 6'd0, 6'd0, 32'h30 + i, 32'h40 + i, 2'b11);
         cyc();
      end
      in_valid = 1'b0;
      chk("pre_async_count", 192'(count0), 192'(2));
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_count", 192'(count0), 192'(0));
      chk("async_out_valid", 192'(out_valid0), 192'(0));
      chk("async_in_ready", 192'(in_ready0), 192'(0));
      reset_n = 1'b1;
      #1;
      chk("async_release_in_ready", 192'(in_ready0), 192'(1));
      drive_in(96'hF5, 6'd0, 6'd0, 32'h9, 32'hA, 2'b11);
      cyc();
      in_valid = 1'b0;
      exp_q.push_back({96'hF5, 32'hA, 32'h9});
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      chk("scoreboard_drained", 192'(exp_q.size()), 192'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/operand_forward_buffer.md
OPERAND_FORWARD_BUFFER -- requirements
Module: operand_forward_buffer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- XLEN, 32, operand data width.
- TAG_WIDTH, 6, rename tag width.
- SRC_COUNT, 2, source operands per instruction.
- CDB_COUNT, 2, common data bus channels.
- DEPTH, 4, buffer entries; power of 2, at least 2.
- PAYLOAD_W, 96, pass-through bits (address, immediate, name, flags).
- WAIT_OPERANDS, 0, mode: 0 presents the head entry as soon as it exists; 1 presents the head only when every operand is valid.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  issue request.
- in_ready  out  1  buffer can accept.
- in_tag  in  SRC_COUNT*TAG_WIDTH  source rename tags.
- in_rf_data  in  SRC_COUNT*XLEN  register-file values.
- in_rf_valid  in  SRC_COUNT  register-file value ready.
- in_payload  in  PAYLOAD_W  pass-through bits.
- cdb_valid  in  CDB_COUNT  broadcast valid.
- cdb_tag  in  CDB_COUNT*TAG_WIDTH  broadcast tag.
- cdb_data  in  CDB_COUNT*XLEN  broadcast data.
- flush  in  1  discard all entries.
- out_valid  out  1  head presented.
- out_ready  in  1  consumer accepts.
- out_payload  out  PAYLOAD_W  head payload.
- out_data  out  SRC_COUNT*XLEN  head operands.
- out_op_valid  out  SRC_COUNT  head operand valid.
- count  out  log2(DEPTH)+1  occupied entries.

Function
REQ-004 Storage SHALL be an in-order circular FIFO with DEPTH entries; read and write pointers SHALL wrap modulo DEPTH.
REQ-005 in_ready SHALL be 1 exactly when count < DEPTH and flush = 0; a full buffer SHALL NOT accept an enqueue, even in a cycle with a dequeue.
REQ-006 Enqueue SHALL occur when in_valid and in_ready are both 1; each operand is captured on the next rising edge.
REQ-007 Enqueue operand capture SHALL use this priority:
- a CDB match on the lowest-index channel wins (CDB data is always newer than register-file data);
- otherwise the register-file value is used, with its in_rf_valid flag.
REQ-008 A CDB match SHALL require cdb_valid = 1, cdb_tag equal to the operand tag, and a tag that is not 0; tag 0 SHALL never match.
REQ-009 Every cycle, each stored operand with valid = 0 SHALL snoop all CDB channels and capture the matching data with valid = 1 (lowest index wins); an operand with valid = 1 SHALL never be overwritten.
REQ-010 The head outputs SHALL be combinational from the head entry; an invalid head operand matching the CDB in the current cycle SHALL be forwarded with out_op_valid = 1 in that same cycle (zero-latency bypass).
REQ-011 When WAIT_OPERANDS = 0, out_valid SHALL equal (count > 0).
REQ-012 When WAIT_OPERANDS = 1, out_valid SHALL equal (count > 0) AND every bypassed head operand being valid.
REQ-013 Dequeue SHALL occur when out_valid and out_ready are both 1; out_data and out_payload SHALL be held stable while out_valid = 1 and out_ready = 0, apart from operand valid transitions from 0 to 1.
REQ-014 A simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-015 Latency from enqueue to out_valid SHALL be 1 cycle when operands are ready (WAIT_OPERANDS = 1) or unconditionally (WAIT_OPERANDS = 0).
REQ-016 Flush SHALL take priority over enqueue and dequeue: count and both pointers SHALL be 0 after the edge; an enqueue in the flush cycle is dropped; a dequeue in the flush cycle is ignored.
REQ-017 When WAIT_OPERANDS = 0, out_valid SHALL still be 1 during a flush cycle if count > 0; the consumer SHALL ignore it.
REQ-018 outputs for unused SRC_COUNT lanes do not exist; all widths derive from the parameters only.

Reset
REQ-019 While reset_n = 0 the block SHALL hold count = 0, both pointers = 0, every entry operand valid = 0, out_valid = 0, and in_ready = 0.
REQ-020 Reset SHALL take effect asynchronously, including mid-operation; in_ready SHALL become 1 in the first cycle after reset_n rises.

Verification
REQ-021 Enqueue with tag 5, rf_valid 0, and cdb[1] = {valid 1, tag 5, data 0xAA} in the same cycle -> next cycle out_data lane 0 = 0xAA and out_op_valid = 1.
REQ-022 cdb[0] and cdb[1] both carry tag 7 (data 0x11 and 0x22) while a stored operand waits on tag 7 -> the operand captures 0x11.
REQ-023 With WAIT_OPERANDS = 1, head waits on tag 3 and out_ready = 1; cdb tag 3 data 0x5 arrives at cycle N -> out_valid = 1 at cycle N with out_data = 0x5, and the entry is dequeued at the edge.
REQ-024 Fill 4 entries with out_ready = 0 -> in_ready = 0 and count = 4; then apply out_ready = 1 and in_valid = 1 for one cycle -> count = 3 (no enqueue while full).
REQ-025 Buffer holds 3 entries; assert flush together with in_valid -> next cycle count = 0 and out_valid = 0.
REQ-026 Drop reset_n for 1 ns mid-stream -> count = 0 and out_valid = 0 immediately, without waiting for a clock edge.
